tiny_dnn_seq: RTL and testbench
===============================

// Module: tiny_dnn_seq
// PURPOSE
//  Upstream sequencer for a bank of N_CORE tiny_dnn_core MAC cores computing one fully-connected layer slice.
//  Holds the input activation vector and drives the shared init/exec/bias/a/d buses.
//  Captures every core's sum once accumulation completes.
//  Streams the N_CORE results out over a valid/ready handshake to the activation stage.
// PARAMETERS
//  N_CORE   16    number of tiny_dnn_core instances driven in parallel (>=1)
//  F_SIZE   1024  core weight depth; address F_SIZE-1 is the bias slot, so max in_size = F_SIZE-1
// PORTS
//  clk        in   1     single clock, all logic posedge
//  reset      in   1     synchronous, active-high
//  buf_we     in   1     write input buffer (honoured only in IDLE)
//  buf_addr   in   10    input buffer write address
//  buf_wd     in   real  input activation value
//  start      in   1     begin a pass (honoured only in IDLE)
//  in_size    in   10    vector length for the pass, sampled on start, 0..F_SIZE-1
//  busy       out  1     high in every state except IDLE
//  done       out  1     one-cycle pulse on the last accepted output beat
//  core_init  out  1     to all cores: clear sum
//  core_exec  out  1     to all cores: MAC step
//  core_bias  out  1     to all cores: add bias weight
//  core_a     out  10    to all cores: weight address
//  core_d     out  real  to all cores: activation, lagging core_a by one cycle
//  core_sum   in   real [N_CORE]  sum outputs of the cores
//  out_valid  out  1     result beat valid
//  out_ready  in   1     downstream accepts beat
//  out_idx    out  $clog2(N_CORE)  core index of the beat
//  out_data   out  real  captured sum of core out_idx
// BEHAVIOUR
//  Reset values: busy=0, done=0, core_init/exec/bias=0, core_a=0, core_d=0.0, out_valid=0, out_idx=0, out_data=0.0.
//  Reset mid-pass forces IDLE and discards captured sums. Buffer contents are not cleared.
//  FSM: IDLE -> INIT -> EXEC -> BIAS -> DRAIN -> CAPT -> OUT -> IDLE.
//  - IDLE:  start=1 latches in_size into n and moves to INIT. buf_we writes buf[buf_addr]<=buf_wd.
//  - INIT:  1 cycle, core_init=1. Next state is EXEC if n>0, else BIAS.
//  - EXEC:  n cycles, k=0..n-1: core_exec=1, core_a=k.
//  - core_d is a registered read of buf[core_a] and carries buf[k] in the cycle after core_a=k.
//    This matches the core's one-cycle weight read; the core multiplies w*d in that later cycle.
//  - BIAS:  1 cycle, core_bias=1, core_a=F_SIZE-1 (the core overrides the address anyway).
//    core_d=buf[n-1] in this cycle, so the last MAC step lands here.
//  - DRAIN: 1 cycle; the cores add the bias weight.
//  - CAPT:  1 cycle; capture all N_CORE core_sum values into a local register array.
//  - OUT:   out_valid=1, out_idx=j, out_data=cap[j], starting at j=0.
//    A beat transfers when out_valid&out_ready; j then increments.
//    out_idx/out_data hold stable while out_ready=0.
//    On the transfer at j=N_CORE-1, done pulses in that same cycle and the FSM returns to IDLE; out_valid drops the next cycle.
//  Latency from start to first out_valid: n+5 cycles (INIT, n x EXEC, BIAS, DRAIN, CAPT).
//  core_init, core_exec and core_bias are mutually exclusive. core_init is never asserted while the cores' exec1 could be pending.
//  start while busy is ignored. buf_we while busy is ignored (buffer stays stable during a pass).
//  in_size >= F_SIZE is clamped to F_SIZE-1. in_size=0 gives results equal to the bias weights.
//  start and buf_we together in IDLE: the write completes and the pass starts; the pass uses the new value.
// TESTING
//  1 reset: 1 cycle in any state -> next cycle all outputs at reset values, busy=0.
//    Mid-EXEC reset, then a new pass -> correct results.
//  2 dot: N_CORE=2, buf={1.0,2.0,3.0}, W0={1,1,1,b=0.5}, W1={0,-1,2,b=0}, in_size=3
//    -> beats (0,6.5),(1,4.0), first out_valid 8 cycles after start.
//  3 zero length: in_size=0, biases {0.25,-1.0} -> beats (0,0.25),(1,-1.0), out_valid 5 cycles after start.
//  4 backpressure: out_ready low 3 cycles on beat 0, then toggling
//    -> no beat lost or duplicated, data stable while stalled, done once.
//  5 ignored controls: start and buf_we during EXEC -> pass unaffected, buffer unchanged, single done.
//  6 bus timing check: core_d == buf[core_a] one cycle later for all k, including at BIAS.
//    in_size=1023 -> core_a reaches 1022, then bias.

Source files
------------

// File: rtl/tiny_dnn_seq.sv
// Sequencer for a bank of tiny_dnn_core MAC cores: broadcasts one activation vector,
// captures every core's sum and streams the results out over a valid/ready port.
module tiny_dnn_seq #(
    parameter int N_CORE = 16,
    parameter int F_SIZE = 1024,
    localparam int AW = $clog2(F_SIZE),
    localparam int IW = (N_CORE > 1) ? $clog2(N_CORE) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          buf_we,
    input  logic [AW-1:0] buf_addr,
    input  real           buf_wd,
    input  logic          start,
    input  logic [AW-1:0] in_size,
    output logic          busy,
    output logic          done,
    output logic          core_init,
    output logic          core_exec,
    output logic          core_bias,
    output logic [AW-1:0] core_a,
    output real           core_d,
    input  real           core_sum [N_CORE],
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_idx,
    output real           out_data,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_EXEC  = 3'd2,
        S_BIAS  = 3'd3,
        S_DRAIN = 3'd4,
        S_CAPT  = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] n_q, n_d;
    logic [AW-1:0] core_a_q, core_a_d;
    logic          core_init_q, core_init_d;
    logic          core_exec_q, core_exec_d;
    logic          core_bias_q, core_bias_d;
    logic          busy_q, busy_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    real           core_d_q, core_d_d;
    logic          buf_wr;
    logic          cap_en;
    logic          last_beat;

    real buf_q [F_SIZE];
    real cap_q [N_CORE];

    // Output handshake: a beat transfers in any cycle where out_valid & out_ready;
    // out_valid never drops and out_idx/out_data never change until that happens.
    assign last_beat = (out_idx_q == IW'(N_CORE - 1));
    assign done      = out_valid_q & out_ready & last_beat;

    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        core_a_d    = '0;
        core_init_d = 1'b0;
        core_exec_d = 1'b0;
        core_bias_d = 1'b0;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        buf_wr      = 1'b0;
        cap_en      = 1'b0;
        // Registered read: core_d carries buf[k] one cycle after core_a = k.
        core_d_d    = buf_q[core_a_q];
        case (state_q)
            S_IDLE: begin
                buf_wr = buf_we;
                if (start) begin
                    n_d         = (32'(in_size) > 32'(F_SIZE - 1)) ? AW'(F_SIZE - 1) : in_size;
                    state_d     = S_INIT;
                    core_init_d = 1'b1;
                end
            end
            S_INIT: begin
                if (n_q != '0) begin
                    state_d     = S_EXEC;
                    core_exec_d = 1'b1;
                end else begin
                    state_d     = S_BIAS;
                    core_bias_d = 1'b1;
                    core_a_d    = AW'(F_SIZE - 1);
                end
            end
            S_EXEC: begin
                if (core_a_q == n_q - 1'b1) begin
                    state_d     = S_BIAS;
                    core_bias_d = 1'b1;
                    core_a_d    = AW'(F_SIZE - 1);
                end else begin
                    core_exec_d = 1'b1;
                    core_a_d    = core_a_q + 1'b1;
                end
            end
            S_BIAS:  state_d = S_DRAIN;
            S_DRAIN: state_d = S_CAPT;
            S_CAPT: begin
                cap_en      = 1'b1;
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_idx_d   = '0;
            end
            S_OUT: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    if (last_beat) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_idx_d   = '0;
                    end else begin
                        out_idx_d = out_idx_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            core_a_q    <= '0;
            core_init_q <= 1'b0;
            core_exec_q <= 1'b0;
            core_bias_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            core_d_q    <= 0.0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            core_a_q    <= core_a_d;
            core_init_q <= core_init_d;
            core_exec_q <= core_exec_d;
            core_bias_q <= core_bias_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            core_d_q    <= core_d_d;
        end
    end

    // Captured sums are dropped on reset so a stale pass can never be streamed out.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CORE; i++) cap_q[i] <= 0.0;
        end else if (cap_en) begin
            for (int i = 0; i < N_CORE; i++) cap_q[i] <= core_sum[i];
        end
    end

    // The activation buffer keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (buf_wr) buf_q[buf_addr] <= buf_wd;
    end

    assign busy      = busy_q;
    assign core_init = core_init_q;
    assign core_exec = core_exec_q;
    assign core_bias = core_bias_q;
    assign core_a    = core_a_q;
    assign core_d    = core_d_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = cap_q[out_idx_q];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tiny_dnn_seq.sv
// Bench for tiny_dnn_seq: emulates two MAC cores on the shared buses and checks the
// streamed results against a dot-product reference plus bus-timing and handshake rules.
module tb_tiny_dnn_seq;

    localparam int N  = 2;
    localparam int F  = 1024;
    localparam int AW = 10;
    localparam int IW = 1;
    localparam int EW = IW + 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          buf_we;
    logic [AW-1:0] buf_addr;
    real           buf_wd;
    logic          start;
    logic [AW-1:0] in_size;
    logic          busy, done, core_init, core_exec, core_bias;
    logic [AW-1:0] core_a;
    real           core_d;
    real           sum_q [N];
    logic          out_valid, out_ready;
    logic [IW-1:0] out_idx;
    real           out_data;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int cur_n = 0;
    int kexp = 0;

    real w [N][F];
    real mbuf [F];
    real wr_q [N];
    logic exec1_q = 1'b0;
    logic bias1_q = 1'b0;
    logic [EW-1:0] exp_q[$];

    typedef struct {
        int  n;
        real b0, b1, b2;
        real w00, w01, w02, wb0;
        real w10, w11, w12, wb1;
        int  lat;
        real e0, e1;
        int  mode;
    } vec_t;

    vec_t vecs [3];

    tiny_dnn_seq #(.N_CORE(N), .F_SIZE(F)) dut (
        .clk(clk), .reset(reset), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wd(buf_wd),
        .start(start), .in_size(in_size), .busy(busy), .done(done),
        .core_init(core_init), .core_exec(core_exec), .core_bias(core_bias),
        .core_a(core_a), .core_d(core_d), .core_sum(sum_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Core emulation: one-cycle weight read, MAC on the cycle after exec, bias add after bias.
    always @(posedge clk) begin
        exec1_q <= core_exec;
        bias1_q <= core_bias;
        for (int c = 0; c < N; c++) begin
            wr_q[c] <= core_bias ? w[c][F-1] : w[c][core_a];
            if (core_init)    sum_q[c] <= 0.0;
            else if (exec1_q) sum_q[c] <= sum_q[c] + wr_q[c] * core_d;
            else if (bias1_q) sum_q[c] <= sum_q[c] + wr_q[c];
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: bus timing, control exclusivity, handshake stability and the scoreboard.
    logic          prev_exec = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic          prev_stall = 1'b0;
    logic [IW-1:0] prev_idx = '0;
    logic [63:0]   prev_data = '0;
    always @(negedge clk) begin
        if (reset) begin
            prev_exec  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_exec) chk("core_d_lag", $realtobits(core_d), $realtobits(mbuf[prev_a]));
            chk("ctl_excl", 128'((32'(core_init) + 32'(core_exec) + 32'(core_bias)) <= 1), 128'(1));
            if (core_init) kexp = 0;
            if (core_exec) begin
                chk("core_a_exec", core_a, 128'(kexp));
                kexp++;
            end
            if (core_bias) begin
                chk("core_a_bias", core_a, 128'(F - 1));
                chk("exec_count", 128'(kexp), 128'(cur_n));
            end
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_idx", out_idx, prev_idx);
                chk("stall_data", $realtobits(out_data), prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat_unexpected", {out_idx, $realtobits(out_data)}, '0);
                end else begin
                    chk("beat", {out_idx, $realtobits(out_data)}, exp_q.pop_front());
                end
                chk("done_pulse", done, out_idx == IW'(N - 1));
            end else begin
                chk("done_quiet", done, 0);
            end
            if (done) done_cnt++;
            prev_exec  = core_exec;
            prev_a     = core_a;
            prev_stall = out_valid && !out_ready;
            prev_idx   = out_idx;
            prev_data  = $realtobits(out_data);
        end
    end

    function automatic real rnd_val();
        return real'(int'($urandom_range(0, 32)) - 16) / 4.0;
    endfunction

    function automatic vec_t mk(input int n, input real b0, input real b1, input real b2,
                                input real w00, input real w01, input real w02, input real wb0,
                                input real w10, input real w11, input real w12, input real wb1,
                                input int lat, input real e0, input real e1, input int mode);
        vec_t v;
        v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.w00 = w00; v.w01 = w01; v.w02 = w02; v.wb0 = wb0;
        v.w10 = w10; v.w11 = w11; v.w12 = w12; v.wb1 = wb1;
        v.lat = lat; v.e0 = e0; v.e1 = e1; v.mode = mode;
        return v;
    endfunction

    task automatic push_exp(input int c, input real v);
        exp_q.push_back({IW'(c), $realtobits(v)});
    endtask

    // Reference: each core's result is its dot product over the first n entries plus its bias.
    task automatic push_model(input int n);
        for (int c = 0; c < N; c++) begin
            real s = 0.0;
            for (int k = 0; k < n; k++) s += w[c][k] * mbuf[k];
            s += w[c][F-1];
            push_exp(c, s);
        end
    endtask

    task automatic write_buf(input int a, input real v);
        buf_we = 1'b1; buf_addr = AW'(a); buf_wd = v; mbuf[a] = v;
        @(posedge clk); #1;
        buf_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_ctl"}, {core_init, core_exec, core_bias}, 0);
        chk({tag, "_core_a"}, core_a, 0);
        chk({tag, "_core_d"}, $realtobits(core_d), $realtobits(0.0));
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_idx"}, out_idx, 0);
        chk({tag, "_data"}, $realtobits(out_data), $realtobits(0.0));
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // mode 0: always ready, 1: stall 3 cycles then toggle, 2: random ready.
    task automatic run_pass(input int n, input int mode, input int exp_lat, input bit poke);
        int lat = 0;
        int cyc = 0;
        int stall = 0;
        cur_n = n; done_cnt = 0;
        out_ready = (mode == 0);
        start = 1'b1; in_size = AW'(n);
        do begin
            @(posedge clk); #1; lat++;
            start = 1'b0; buf_we = 1'b0;
            if (poke && lat == 3) begin
                start = 1'b1; in_size = AW'(n / 2);
                buf_we = 1'b1; buf_addr = AW'(n - 1); buf_wd = 123.5;
            end
        end while (!out_valid && lat < exp_lat + 10);
        start = 1'b0; buf_we = 1'b0;
        chk("latency", 128'(lat), 128'(exp_lat));
        while (busy && cyc < 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    if (stall < 3) out_ready = 1'b0;
                    else           out_ready = ~out_ready;
                    stall++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            @(posedge clk); #1; cyc++;
        end
        chk("pass_end_busy", busy, 0);
        chk("beats_left", 128'(exp_q.size()), 0);
        chk("done_count", 128'(done_cnt), 1);
        chk("valid_after", out_valid, 0);
        out_ready = 1'b0;
        exp_q.delete();
    endtask

    task automatic reset_mid(input int n, input int cycles, input string tag);
        cur_n = n; out_ready = 1'b0;
        start = 1'b1; in_size = AW'(n);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_outputs(tag);
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; buf_we = 1'b0; buf_addr = '0; buf_wd = 0.0;
        start = 1'b0; in_size = '0; out_ready = 1'b0;
        for (int c = 0; c < N; c++) begin
            sum_q[c] = 0.0; wr_q[c] = 0.0;
            for (int a = 0; a < F; a++) w[c][a] = 0.0;
        end
        for (int a = 0; a < F; a++) mbuf[a] = 0.0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_outputs("rst_init");

        vecs[0] = mk(3, 1.0, 2.0, 3.0,   1.0, 1.0, 1.0, 0.5,   0.0, -1.0, 2.0, 0.0,   8, 6.5, 4.0, 0);
        vecs[1] = mk(0, 0.0, 0.0, 0.0,   0.0, 0.0, 0.0, 0.25,  0.0, 0.0, 0.0, -1.0,   5, 0.25, -1.0, 0);
        vecs[2] = mk(2, 0.5, -2.0, 7.0,  2.0, 1.0, 9.0, 1.0,  -1.0, 0.5, 9.0, -0.25,  7, 0.0, -1.75, 1);
        for (int i = 0; i < 3; i++) begin
            write_buf(0, vecs[i].b0); write_buf(1, vecs[i].b1); write_buf(2, vecs[i].b2);
            w[0][0] = vecs[i].w00; w[0][1] = vecs[i].w01; w[0][2] = vecs[i].w02; w[0][F-1] = vecs[i].wb0;
            w[1][0] = vecs[i].w10; w[1][1] = vecs[i].w11; w[1][2] = vecs[i].w12; w[1][F-1] = vecs[i].wb1;
            push_exp(0, vecs[i].e0);
            push_exp(1, vecs[i].e1);
            run_pass(vecs[i].n, vecs[i].mode, vecs[i].lat, 1'b0);
        end

        reset_mid(10, 5, "rst_exec");
        for (int c = 0; c < N; c++)
            for (int a = 0; a < F; a++) w[c][a] = rnd_val();
        for (int a = 0; a < F; a++) write_buf(a, rnd_val());

        for (int i = 0; i < 6; i++) begin
            int n = $urandom_range(0, 40);
            push_model(n);
            run_pass(n, $urandom_range(0, 2), n + 5, 1'b0);
        end

        push_model(8);
        run_pass(8, 0, 13, 1'b1);

        reset_mid(3, 8, "rst_out");
        push_model(3);
        run_pass(3, 1, 8, 1'b0);

        buf_we = 1'b1; buf_addr = AW'(4); buf_wd = 5.75; mbuf[4] = 5.75;
        push_model(5);
        run_pass(5, 2, 10, 1'b0);

        push_model(F - 1);
        run_pass(F - 1, 2, F + 4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
